// File: rtl/led_ctrl_mmio.sv
// led_ctrl_mmio: memory-mapped LED controller with static pattern, per-LED blink mask and blink period; `LED_PWM_EN adds a DUTY register with PWM dimming
module led_ctrl_mmio #(
  parameter int ANCHO      = 32,
  parameter int NLEDS      = 16,
  parameter int BASE       = 'h310,
  parameter int PRESC_W    = 26,
  parameter int PERIOD_RST = 49_999_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] Dir,
  input  logic [ANCHO-1:0] Entrada,
  input  logic             WE,
  output logic [ANCHO-1:0] Salida,
  output logic [NLEDS-1:0] led
);
  localparam logic [ANCHO-3:0] B = (ANCHO-2)'(BASE >> 2);
  logic [ANCHO-3:0] wa;
  logic sel_data, sel_mode, sel_period;
  logic [NLEDS-1:0] data, mode, led_next;
  logic [PRESC_W-1:0] period, cnt;
  logic phase, pwm_on;
  logic [ANCHO-1:0] rd_duty;
  logic unused;
  assign wa = Dir[ANCHO-1:2];
  assign sel_data = wa == B;
  assign sel_mode = wa == B + (ANCHO-2)'(1);
  assign sel_period = wa == B + (ANCHO-2)'(2);
  assign unused = ^{Dir[1:0], Entrada};
`ifdef LED_PWM_EN
  logic sel_duty;
  logic [7:0] duty, pwm;
  assign sel_duty = wa == B + (ANCHO-2)'(3);
  assign pwm_on = (duty == 8'hFF) | (pwm < duty);
  assign rd_duty = sel_duty ? ANCHO'(duty) : '0;
  // DUTY register and free-running 8-bit PWM counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      duty <= 8'hFF;
      pwm <= '0;
    end else begin
      pwm <= pwm + 8'd1;
      if (WE && sel_duty) duty <= Entrada[7:0];
    end
  end
`else
  assign pwm_on = 1'b1;
  assign rd_duty = '0;
`endif
  // Read-back mux: addressed register zero-extended, everything else reads 0
  always_comb begin
    Salida = sel_data ? ANCHO'(data) : sel_mode ? ANCHO'(mode) : sel_period ? ANCHO'(period) : rd_duty;
  end
  // Pattern and mode registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      data <= '0;
      mode <= '0;
    end else begin
      if (WE && sel_data) data <= Entrada[NLEDS-1:0];
      if (WE && sel_mode) mode <= Entrada[NLEDS-1:0];
    end
  end
  // Blink engine; a PERIOD write restarts the phase from zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      period <= PRESC_W'(PERIOD_RST);
      cnt <= '0;
      phase <= 1'b0;
    end else if (WE && sel_period) begin
      period <= Entrada[PRESC_W-1:0];
      cnt <= '0;
      phase <= 1'b0;
    end else if (cnt == period) begin
      cnt <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + PRESC_W'(1);
    end
  end
  // Blinking LEDs follow phase, static ones follow DATA; all gated by PWM
  always_comb begin
    led_next = data & (~mode | {NLEDS{phase}}) & {NLEDS{pwm_on}};
  end
  // Registered LED drive
  always_ff @(posedge clk) begin
    if (!rst) led <= '0;
    else led <= led_next;
  end
endmodule

// File: tb/tb_led_ctrl_mmio.sv
// tb_led_ctrl_mmio: random and directed checks of led_ctrl_mmio against a time-based behavioural model
module tb_led_ctrl_mmio;
  logic clk = 0, rst = 1, WE = 0;
  logic [31:0] Dir = 0, Entrada = 0, Salida;
  logic [15:0] led;
  int vectors = 0, miscompares = 0;
  bit known = 0;
  logic [15:0] m_data, m_mode, m_led;
  logic [25:0] m_period;
  longint n = 0, r = 0;
  bit m_ph;

  led_ctrl_mmio dut (.clk(clk), .rst(rst), .Dir(Dir), .Entrada(Entrada), .WE(WE), .Salida(Salida), .led(led));

  always #5 clk = ~clk;

  function automatic int off(input logic [31:0] d);
    longint k = longint'(d >> 2) - longint'('h310 >> 2);
    return (k >= 0 && k <= 3) ? int'(k) : -1;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] d);
    int k = off(d);
    return k == 0 ? {16'b0, m_data} : k == 1 ? {16'b0, m_mode} : k == 2 ? {6'b0, m_period} : 32'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rv, input bit we, input logic [31:0] d, input logic [31:0] din);
    int k;
    rst = rv; WE = we; Dir = d; Entrada = din;
    #1;
    if (known) chk("salida", Salida, rd(d));
    @(posedge clk);
    n++;
    k = off(d);
    if (!rv) begin
      m_data = 0; m_mode = 0; m_period = 26'd49_999_999; r = n; m_led = 0; known = 1;
    end else begin
      m_led = m_data & (~m_mode | {16{m_ph}});
      if (we && k == 0) m_data = din[15:0];
      if (we && k == 1) m_mode = din[15:0];
      if (we && k == 2) begin m_period = din[25:0]; r = n; end
    end
    m_ph = (((n - r) / (longint'(m_period) + 1)) % 2) == 1;
    #1;
    if (known) chk("led", {16'b0, led}, {16'b0, m_led});
  endtask

  initial begin
    logic [31:0] d, din;
    for (int i = 0; i < 3; i++) step(0, 1, 'h310, 'hFFFF);
    chk("reset_led", {16'b0, led}, 0);
    step(1, 0, 'h310, 0); chk("reset_data", Salida, 0);
    step(1, 0, 'h318, 0); chk("reset_period", Salida, 49_999_999);
    step(1, 1, 'h310, 'hA5A5_1234);
    step(1, 0, 'h310, 0);
    chk("static_led", {16'b0, led}, 'h1234);
    chk("static_read", Salida, 'h1234);
    step(1, 1, 'h310, 'h00FF);
    step(1, 1, 'h314, 'h000F);
    step(1, 1, 'h318, 3);
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 'h318, 0);
      if (i == 1) chk("blink_first", {16'b0, led}, 'h00F0);
      if (i == 4) chk("blink_off", {16'b0, led}, 'h00F0);
      if (i == 6) chk("blink_on", {16'b0, led}, 'h00FF);
    end
    step(1, 1, 'h318, 3);
    step(1, 0, 'h318, 0);
    chk("period_restart", {16'b0, led}, 'h00F0);
    for (int i = 0; i < 4; i++) step(1, 0, 'h310, 0);
    chk("pre_reset_on", {16'b0, led}, 'h00FF);
    step(0, 1, 'h310, 'hFFFF);
    chk("mid_reset_led", {16'b0, led}, 0);
    step(1, 0, 'h314, 0); chk("mid_reset_mode", Salida, 0);
    step(1, 0, 'h318, 0); chk("mid_reset_period", Salida, 49_999_999);
    step(1, 1, 'h320, 'hFFFF_FFFF); chk("miss_320", Salida, 0);
    step(1, 1, 'h30C, 'hFFFF_FFFF); chk("miss_30C", Salida, 0);
    step(1, 1, 'h31C, 'hFFFF_FFFF); chk("unmapped_31C", Salida, 0);
    step(1, 0, 'h310, 0); chk("no_write_data", Salida, 0);
    step(1, 0, 'h314, 0); chk("no_write_mode", Salida, 0);
    step(1, 1, 'h313, 'h0003);
    step(1, 0, 'h310, 0); chk("unaligned_write", Salida, 3);
    for (int i = 0; i < 3000; i++) begin
      d = 32'h310 + 32'($urandom_range(0, 7) * 4) - 32'd8 + 32'($urandom_range(0, 3));
      din = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 9));
      step($urandom_range(0, 63) != 0, $urandom_range(0, 1) == 1, d, din);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
